// File: rtl/fsm_mestre_linha_pkg.sv
// -----------------------------------------------------------------------------
// fsm_mestre_linha_pkg
// Shared definitions for the bottling-line master controller and its helpers:
// the controller state encoding, the default batch size and the default wait
// supervision limit (10 s at 50 MHz).
// -----------------------------------------------------------------------------
package fsm_mestre_linha_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENCH    = 3'd1,
        VEDA    = 3'd2,
        LIBERA  = 3'd3,
        CONTA   = 3'd4,
        LOTE_OK = 3'd5,
        ERRO    = 3'd6
    } estado_t;

    localparam int unsigned          TW_PADRAO      = 29;
    localparam logic [7:0]           LOTE_PADRAO    = 8'd12;
    localparam logic [TW_PADRAO-1:0] TIMEOUT_PADRAO = 29'd500_000_000;

    // States in which the controller is waiting on a slave and is supervised.
    function automatic logic em_espera(input estado_t e);
        return (e == ENCH) || (e == VEDA) || (e == LIBERA);
    endfunction

endpackage

// File: rtl/fsm_mestre_linha_if.sv
// -----------------------------------------------------------------------------
// fsm_mestre_linha_if
// 4-phase command/acknowledge bundle between the line master and the filling
// and capping slaves.
//   cmd_enchimento    master -> filling slave command
//   cmd_vedacao       master -> capping slave command
//   garrafa_concluida master -> both slaves, release strobe (level)
//   ench_concluida    filling slave -> master, task done
//   veda_concluida    capping slave -> master, task done
// -----------------------------------------------------------------------------
interface fsm_mestre_linha_if;

    logic cmd_enchimento;
    logic cmd_vedacao;
    logic garrafa_concluida;
    logic ench_concluida;
    logic veda_concluida;

    modport master (
        output cmd_enchimento,
        output cmd_vedacao,
        output garrafa_concluida,
        input  ench_concluida,
        input  veda_concluida
    );

    modport slave (
        input  cmd_enchimento,
        input  cmd_vedacao,
        input  garrafa_concluida,
        output ench_concluida,
        output veda_concluida
    );

endinterface

// File: rtl/fsm_mestre_linha_temporizador.sv
// -----------------------------------------------------------------------------
// temporizador_timeout
// Wait supervisor: a TW-bit cycle counter that is cleared synchronously and
// advances while enabled. expirado flags the last allowed cycle of a wait
// (count = LIMITE-1) so the owner can leave the wait on the next edge.
//   clk       system clock
//   reset     synchronous, active-high
//   limpar    synchronous clear (has priority over habilitar)
//   habilitar count this cycle
//   expirado  enabled and count has reached LIMITE-1
// -----------------------------------------------------------------------------
module temporizador_timeout
    import fsm_mestre_linha_pkg::*;
#(
    parameter int unsigned    TW     = TW_PADRAO,
    parameter logic [TW-1:0]  LIMITE = TIMEOUT_PADRAO
) (
    input  logic clk,
    input  logic reset,
    input  logic limpar,
    input  logic habilitar,
    output logic expirado
);

    localparam logic [TW-1:0] ULTIMO = LIMITE - TW'(1);

    logic [TW-1:0] valor;

    // Saturates at the last cycle so a stalled owner never sees a wrap.
    always_ff @(posedge clk) begin
        if (reset || limpar) begin
            valor <= '0;
        end else if (habilitar && (valor != ULTIMO)) begin
            valor <= valor + TW'(1);
        end
    end

    assign expirado = habilitar && (valor == ULTIMO);

endmodule

// File: rtl/fsm_mestre_linha.sv
// -----------------------------------------------------------------------------
// fsm_mestre_linha
// Bottling-line master. Sequences one bottle at a time through the filling
// and capping slaves with a 4-phase handshake, releases both slaves, counts
// finished bottles against LOTE and traps into ERRO when any wait exceeds
// TIMEOUT_CICLOS cycles.
//   clk           50 MHz system clock
//   reset         synchronous, active-high
//   iniciar       start request (level), honoured in IDLE and LOTE_OK
//   parar         graceful stop request (latched), current bottle completes
//   continuo      1 = chain bottles until the batch is complete
//   bus           master side of the slave handshake bundle
//   contagem      bottles completed in the current batch
//   lote_completo batch complete (LOTE_OK)
//   erro          wait supervision expired (ERRO, left only by reset)
//   ocupado       bottle in progress
// -----------------------------------------------------------------------------
module fsm_mestre_linha
    import fsm_mestre_linha_pkg::*;
#(
    parameter int unsigned   TW             = TW_PADRAO,
    parameter logic [7:0]    LOTE           = LOTE_PADRAO,
    parameter logic [TW-1:0] TIMEOUT_CICLOS = TIMEOUT_PADRAO
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       iniciar,
    input  logic                       parar,
    input  logic                       continuo,
    fsm_mestre_linha_if.master         bus,
    output logic [7:0]                 contagem,
    output logic                       lote_completo,
    output logic                       erro,
    output logic                       ocupado
);

    estado_t estado;
    estado_t prox;
    logic    parar_lat;
    logic    partida;
    logic    expirado;
    logic    limpa_tmr;
    logic    cmd_ench_r;
    logic    cmd_veda_r;
    logic    garrafa_r;

    // Next-state decision. In every wait the exit condition is tested before
    // the timeout, so an acknowledge on the last allowed cycle still wins.
    always_comb begin
        prox = estado;
        case (estado)
            IDLE:    if (iniciar) prox = ENCH;
            ENCH: begin
                if (bus.ench_concluida)  prox = VEDA;
                else if (expirado)       prox = ERRO;
            end
            VEDA: begin
                if (bus.veda_concluida)  prox = LIBERA;
                else if (expirado)       prox = ERRO;
            end
            LIBERA: begin
                if (!bus.ench_concluida && !bus.veda_concluida) prox = CONTA;
                else if (expirado)                              prox = ERRO;
            end
            // contagem already holds the new count here (incremented on entry).
            CONTA: begin
                if (contagem == LOTE)            prox = LOTE_OK;
                else if (parar_lat || !continuo) prox = IDLE;
                else                             prox = ENCH;
            end
            LOTE_OK: if (iniciar) prox = ENCH;
            ERRO:    prox = ERRO;
            default: prox = IDLE;
        endcase
    end

    assign partida = iniciar && ((estado == IDLE) || (estado == LOTE_OK));

    // Clearing on every state change gives each wait a fresh count from zero.
    assign limpa_tmr = !em_espera(estado) || (prox != estado);

    temporizador_timeout #(
        .TW     (TW),
        .LIMITE (TIMEOUT_CICLOS)
    ) u_temporizador (
        .clk       (clk),
        .reset     (reset),
        .limpar    (limpa_tmr),
        .habilitar (em_espera(estado)),
        .expirado  (expirado)
    );

    // State register; outputs are registered from the state being entered so
    // they line up with estado on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado        <= IDLE;
            contagem      <= '0;
            parar_lat     <= 1'b0;
            cmd_ench_r    <= 1'b0;
            cmd_veda_r    <= 1'b0;
            garrafa_r     <= 1'b0;
            lote_completo <= 1'b0;
            erro          <= 1'b0;
            ocupado       <= 1'b0;
        end else begin
            estado        <= prox;
            cmd_ench_r    <= (prox == ENCH) || (prox == VEDA);
            cmd_veda_r    <= (prox == VEDA);
            garrafa_r     <= (prox == LIBERA);
            lote_completo <= (prox == LOTE_OK);
            erro          <= (prox == ERRO);
            ocupado       <= !((prox == IDLE) || (prox == LOTE_OK) || (prox == ERRO));

            if (partida) begin
                contagem <= '0;
            end else if (prox == CONTA) begin
                contagem <= contagem + 8'd1;
            end

            if (partida || (prox == IDLE)) begin
                parar_lat <= 1'b0;
            end else if (parar && (estado != IDLE)) begin
                parar_lat <= 1'b1;
            end
        end
    end

    assign bus.cmd_enchimento    = cmd_ench_r;
    assign bus.cmd_vedacao       = cmd_veda_r;
    assign bus.garrafa_concluida = garrafa_r;

endmodule

// File: tb/tb_fsm_mestre_linha.sv
// -----------------------------------------------------------------------------
// tb_fsm_mestre_linha
// Bench for fsm_mestre_linha with LOTE=3 and TIMEOUT_CICLOS=20. A behavioural
// model of the line tracks every clock; a fixed vector table, hand-written
// corner sequences and a randomized run are compared against it.
// -----------------------------------------------------------------------------
module tb_fsm_mestre_linha;

    localparam logic [7:0] LOTE_TB = 8'd3;
    localparam int         TO_TB   = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       parar;
    logic       continuo;
    logic [7:0] contagem;
    logic       lote_completo;
    logic       erro;
    logic       ocupado;

    fsm_mestre_linha_if bus();

    fsm_mestre_linha #(
        .TW             (29),
        .LOTE           (LOTE_TB),
        .TIMEOUT_CICLOS (29'd20)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .iniciar       (iniciar),
        .parar         (parar),
        .continuo      (continuo),
        .bus           (bus),
        .contagem      (contagem),
        .lote_completo (lote_completo),
        .erro          (erro),
        .ocupado       (ocupado)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- behavioural model of the line ----------------
    typedef enum int {M_OCIOSO, M_LOTE_FEITO, M_FALHA, M_PEDE_ENCH,
                      M_PEDE_VEDA, M_SOLTA, M_CONTA} mfase_t;

    mfase_t     mf     = M_OCIOSO;
    mfase_t     mnext;
    logic [7:0] mcnt   = 8'd0;
    logic       mpar   = 1'b0;
    int         mesp   = 0;
    logic       inicio;

    always @(posedge clk) begin
        if (reset) begin
            mf   = M_OCIOSO;
            mcnt = 8'd0;
            mpar = 1'b0;
            mesp = 0;
        end else begin
            mnext  = mf;
            inicio = 1'b0;
            case (mf)
                M_OCIOSO, M_LOTE_FEITO:
                    if (iniciar) begin mnext = M_PEDE_ENCH; inicio = 1'b1; end
                M_PEDE_ENCH:
                    if (bus.ench_concluida)   mnext = M_PEDE_VEDA;
                    else if (mesp == TO_TB-1) mnext = M_FALHA;
                M_PEDE_VEDA:
                    if (bus.veda_concluida)   mnext = M_SOLTA;
                    else if (mesp == TO_TB-1) mnext = M_FALHA;
                M_SOLTA:
                    if (!bus.ench_concluida && !bus.veda_concluida) mnext = M_CONTA;
                    else if (mesp == TO_TB-1)                       mnext = M_FALHA;
                M_CONTA:
                    if (mcnt == LOTE_TB)        mnext = M_LOTE_FEITO;
                    else if (mpar || !continuo) mnext = M_OCIOSO;
                    else                        mnext = M_PEDE_ENCH;
                default: mnext = mf;
            endcase
            if (inicio)                mcnt = 8'd0;
            else if (mnext == M_CONTA) mcnt = mcnt + 8'd1;
            if (inicio || mnext == M_OCIOSO)     mpar = 1'b0;
            else if (parar && mf != M_OCIOSO)    mpar = 1'b1;
            mesp = (mnext == mf) ? mesp + 1 : 0;
            mf   = mnext;
        end
    end

    // {cmd_enchimento, cmd_vedacao, garrafa_concluida, contagem, lote_completo, erro, ocupado}
    function automatic logic [13:0] esperado();
        logic ce, cv, gc, lc, er, oc;
        ce = (mf == M_PEDE_ENCH) || (mf == M_PEDE_VEDA);
        cv = (mf == M_PEDE_VEDA);
        gc = (mf == M_SOLTA);
        lc = (mf == M_LOTE_FEITO);
        er = (mf == M_FALHA);
        oc = (mf == M_PEDE_ENCH) || (mf == M_PEDE_VEDA) || (mf == M_SOLTA) || (mf == M_CONTA);
        return {ce, cv, gc, mcnt, lc, er, oc};
    endfunction

    function automatic logic [13:0] obtido();
        return {bus.cmd_enchimento, bus.cmd_vedacao, bus.garrafa_concluida,
                contagem, lote_completo, erro, ocupado};
    endfunction

    task automatic chk(input string nome, input logic [13:0] obt, input logic [13:0] esp);
        checks++;
        if (obt !== esp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nome, obt, esp);
        end
    endtask

    // ---------------- responsive slave stimulus ----------------
    logic auto_esc = 1'b0;
    logic ruido    = 1'b0;
    int   p_resp   = 2;

    task automatic escravo_auto();
        if (bus.garrafa_concluida) begin
            if (bus.ench_concluida && $urandom_range(0, 1) == 0) bus.ench_concluida = 1'b0;
            if (bus.veda_concluida && $urandom_range(0, 1) == 0) bus.veda_concluida = 1'b0;
        end else begin
            if (!bus.cmd_enchimento) bus.ench_concluida = 1'b0;
            else if (!bus.ench_concluida && $urandom_range(0, p_resp-1) == 0) bus.ench_concluida = 1'b1;
            if (!bus.cmd_vedacao) bus.veda_concluida = 1'b0;
            else if (!bus.veda_concluida && $urandom_range(0, p_resp-1) == 0) bus.veda_concluida = 1'b1;
        end
        if (ruido && $urandom_range(0, 49) == 0) bus.ench_concluida = ~bus.ench_concluida;
        if (ruido && $urandom_range(0, 49) == 0) bus.veda_concluida = ~bus.veda_concluida;
    endtask

    // One clock: edge, then compare against the model on the falling edge.
    task automatic ciclo(input string nome);
        @(posedge clk);
        @(negedge clk);
        chk(nome, obtido(), esperado());
        if (auto_esc) escravo_auto();
    endtask

    task automatic aplica(input logic [5:0] ent);
        {reset, iniciar, parar, continuo, bus.ench_concluida, bus.veda_concluida} = ent;
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [5:0] ent;   // {reset, iniciar, parar, continuo, ench, veda}
        logic [2:0] cmds;  // {cmd_enchimento, cmd_vedacao, garrafa_concluida}
        logic [7:0] cnt;
        logic [2:0] st;    // {lote_completo, erro, ocupado}
    } vetor_t;

    vetor_t tab [16];

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit cmd_visto;
        bit achou;

        aplica(6'b100000);

        tab[0]  = '{6'b100000, 3'b000, 8'd0, 3'b000};
        tab[1]  = '{6'b010000, 3'b100, 8'd0, 3'b001};
        tab[2]  = '{6'b000000, 3'b100, 8'd0, 3'b001};
        tab[3]  = '{6'b000000, 3'b100, 8'd0, 3'b001};
        tab[4]  = '{6'b000000, 3'b100, 8'd0, 3'b001};
        tab[5]  = '{6'b000000, 3'b100, 8'd0, 3'b001};
        tab[6]  = '{6'b000010, 3'b110, 8'd0, 3'b001};
        tab[7]  = '{6'b000010, 3'b110, 8'd0, 3'b001};
        tab[8]  = '{6'b000010, 3'b110, 8'd0, 3'b001};
        tab[9]  = '{6'b000011, 3'b001, 8'd0, 3'b001};
        tab[10] = '{6'b000011, 3'b001, 8'd0, 3'b001};
        tab[11] = '{6'b000000, 3'b000, 8'd1, 3'b001};
        tab[12] = '{6'b000000, 3'b000, 8'd1, 3'b000};
        tab[13] = '{6'b000010, 3'b000, 8'd1, 3'b000};
        tab[14] = '{6'b010000, 3'b100, 8'd0, 3'b001};
        tab[15] = '{6'b100000, 3'b000, 8'd0, 3'b000};

        // Single bottle, continuo=0, then spurious ack and restart.
        for (int i = 0; i < 16; i++) begin
            aplica(tab[i].ent);
            ciclo($sformatf("tab_modelo_%0d", i));
            chk($sformatf("tab_%0d", i), obtido(), {tab[i].cmds, tab[i].cnt, tab[i].st});
        end

        // Batch of LOTE_TB bottles with responsive slaves.
        aplica(6'b010100);
        auto_esc = 1'b1;
        p_resp   = 2;
        ciclo("lote_inicio");
        iniciar = 1'b0;
        achou   = 1'b0;
        for (int n = 0; n < 400 && !achou; n++) begin
            ciclo("lote_modelo");
            if (lote_completo) achou = 1'b1;
        end
        chk("lote_completo_alcancado", 14'(achou), 14'd1);
        chk("lote_contagem", 14'(contagem), 14'(LOTE_TB));
        chk("lote_cmds_baixos", 14'({bus.cmd_enchimento, bus.cmd_vedacao}), 14'd0);
        auto_esc = 1'b0;
        aplica(6'b010100);
        ciclo("lote_reinicio");
        chk("lote_reinicio_contagem", 14'(contagem), 14'd0);
        chk("lote_reinicio_cmd", 14'(bus.cmd_enchimento), 14'd1);

        // Graceful stop requested during capping of bottle 1.
        aplica(6'b100100); ciclo("parar_reset");
        aplica(6'b010100); ciclo("parar_ench");
        aplica(6'b000110); ciclo("parar_veda");
        aplica(6'b001110); ciclo("parar_pulso");
        aplica(6'b000111); ciclo("parar_libera");
        aplica(6'b000100); ciclo("parar_conta");
        chk("parar_contagem", 14'(contagem), 14'd1);
        ciclo("parar_idle");
        chk("parar_ocupado", 14'(ocupado), 14'd0);
        cmd_visto = 1'b0;
        for (int n = 0; n < 5; n++) begin
            ciclo("parar_sem_cmd");
            if (bus.cmd_enchimento) cmd_visto = 1'b1;
        end
        chk("parar_sem_novo_cmd", 14'(cmd_visto), 14'd0);

        // Filling slave never answers.
        aplica(6'b100000); ciclo("to_reset");
        aplica(6'b010000); ciclo("to_ench");
        iniciar = 1'b0;
        for (int n = 0; n < TO_TB-1; n++) ciclo("to_espera");
        chk("to_antes_limite", 14'(erro), 14'd0);
        ciclo("to_limite");
        chk("to_erro", 14'(erro), 14'd1);
        chk("to_cmd_baixo", 14'(bus.cmd_enchimento), 14'd0);
        aplica(6'b010010);
        for (int n = 0; n < 5; n++) ciclo("to_preso");
        chk("to_erro_mantido", 14'(erro), 14'd1);
        chk("to_contagem", 14'(contagem), 14'd0);

        // Acknowledge on the last allowed cycle wins over the timeout.
        aplica(6'b100000); ciclo("bord_reset");
        aplica(6'b010000); ciclo("bord_ench");
        iniciar = 1'b0;
        for (int n = 0; n < TO_TB-1; n++) ciclo("bord_espera");
        bus.ench_concluida = 1'b1;
        ciclo("bord_ack");
        chk("bord_veda", 14'(bus.cmd_vedacao), 14'd1);
        chk("bord_sem_erro", 14'(erro), 14'd0);

        // Reset while releasing the second bottle.
        aplica(6'b100100); ciclo("rst_reset");
        aplica(6'b010100); ciclo("rst_ench1");
        aplica(6'b000110); ciclo("rst_veda1");
        aplica(6'b000111); ciclo("rst_libera1");
        aplica(6'b000100); ciclo("rst_conta1");
        ciclo("rst_ench2");
        aplica(6'b000110); ciclo("rst_veda2");
        aplica(6'b000111); ciclo("rst_libera2");
        chk("rst_garrafa_antes", 14'(bus.garrafa_concluida), 14'd1);
        reset = 1'b1;
        #2;
        chk("rst_entre_bordas", 14'({bus.garrafa_concluida, contagem}), {5'd0, 1'b1, 8'd1});
        ciclo("rst_borda");
        chk("rst_tudo_zero", obtido(), 14'd0);
        aplica(6'b000000);

        // Randomized run with noisy, sometimes slow slaves.
        auto_esc = 1'b1;
        ruido    = 1'b1;
        p_resp   = 6;
        for (int n = 0; n < 4000; n++) begin
            reset   = ($urandom_range(0, 99) == 0);
            iniciar = ($urandom_range(0, 3) == 0);
            parar   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) == 0) continuo = ~continuo;
            ciclo("aleatorio");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fsm_mestre_linha.md
Name: fsm_mestre_linha

Overview:
Master controller for the bottling line. Drives the 4-phase command/acknowledge handshake towards the filling stage (fsm_enchimento) and the capping stage (same slave protocol). It sequences one bottle at a time, releases both slaves with garrafa_concluida, and counts finished bottles against a batch size. It also supervises each wait with a timeout and latches an error.

Parameters:
LOTE, 8'd12, bottles per batch; valid range 1..255
TIMEOUT_CICLOS, 29'd500_000_000, maximum clk cycles spent in any wait state (10 s at 50 MHz)
TW, 29, width of the timeout counter; must hold TIMEOUT_CICLOS

Ports:
clk  input  1  50 MHz system clock
reset  input  1  synchronous, active-high; all state is cleared on the clk edge where reset=1
iniciar  input  1  start request, level; sampled only in IDLE and LOTE_OK
parar  input  1  graceful stop request, level; latched
continuo  input  1  1 = chain bottles automatically until the batch is complete; 0 = one bottle per iniciar
ench_concluida  input  1  tarefa_concluida from the filling slave
veda_concluida  input  1  tarefa_concluida from the capping slave
cmd_enchimento  output  1  command to the filling slave
cmd_vedacao  output  1  command to the capping slave
garrafa_concluida  output  1  release strobe to both slaves; level, held through LIBERA
contagem  output  8  bottles completed in the current batch
lote_completo  output  1  high in LOTE_OK
erro  output  1  high in ERRO
ocupado  output  1  high in every state except IDLE, LOTE_OK and ERRO

Behaviour:
- Architecture: Moore FSM. All outputs are registered, or decoded from state only. Reset is synchronous and active-high.
- Reset values: every output is 0; contagem=0; parar latch=0; timer=0; state=IDLE.
- IDLE: when iniciar=1, go to ENCH and clear contagem.
- ENCH:
  - cmd_enchimento=1.
  - When ench_concluida=1, go to VEDA. cmd_enchimento stays 1 so the filling slave holds in its completed state.
- VEDA:
  - cmd_enchimento=1, cmd_vedacao=1.
  - When veda_concluida=1, go to LIBERA.
- LIBERA:
  - Both commands are 0; garrafa_concluida=1.
  - Stay until ench_concluida=0 AND veda_concluida=0, which completes the 4-phase handshake. Then go to CONTA.
- CONTA (exactly 1 cycle):
  - garrafa_concluida=0; contagem increments by 1.
  - Next state is chosen from the new count, in this priority order:
    1. New count equals LOTE: go to LOTE_OK.
    2. Else, parar latch set or continuo=0: go to IDLE.
    3. Else: go to ENCH.
  - contagem is kept when returning to IDLE, and cleared on the next start.
- LOTE_OK:
  - lote_completo=1.
  - When iniciar=1, clear contagem and the parar latch, then go to ENCH.
- ERRO:
  - erro=1; all commands and garrafa_concluida are 0.
  - Exit only through reset. contagem is frozen.
- Timeout:
  - The timer clears on entry to ENCH, VEDA and LIBERA, and counts every cycle spent in those states.
  - When timer reaches TIMEOUT_CICLOS-1 and the exit condition is still false, the next state is ERRO.
  - If the exit condition and the timeout occur in the same cycle, the exit condition wins.
- parar handling: parar=1 in any state other than IDLE sets the latch. The current bottle is always completed, never aborted. The latch clears on entry to IDLE and on a new start.
- A spurious acknowledge (ench_concluida or veda_concluida high in IDLE) is ignored. ENCH still waits for ench_concluida, so a stuck-high acknowledge advances immediately. This is acceptable and is covered by the timeout only in LIBERA.
- Reset during any handshake: the commands drop on the next edge; the slaves recover through their own reset.
- Counter width rule: contagem is 8 bits unsigned. It never exceeds LOTE, so it cannot wrap.

Decomposition:
- Shared package/include holds the state encodings (IDLE, ENCH, VEDA, LIBERA, CONTA, LOTE_OK, ERRO in 3 bits) and the default TIMEOUT_CICLOS and LOTE constants.
- One sub-module is natural: temporizador_timeout (clear, enable, TW-bit counter, expirado flag). It is reusable by the slave stages.

Test Plan:
- Single bottle, continuo=0:
  - Stimulus: iniciar pulse; ench_concluida rises 5 cycles later; veda_concluida rises 3 cycles after that; both drop 2 cycles after garrafa_concluida rises.
  - Response: cmd_enchimento high from cycle 1; cmd_vedacao follows one cycle after ench_concluida; garrafa_concluida high until both acks are low; contagem=1; back in IDLE with ocupado=0.
- Batch, LOTE=3, continuo=1:
  - Stimulus: 3 bottles with responsive slave models.
  - Response: lote_completo=1 after the third CONTA; contagem=3; cmds stay low. A new iniciar resets contagem to 0.
- Graceful stop:
  - Stimulus: parar pulsed while in VEDA during bottle 1 of LOTE=5, continuo=1.
  - Response: bottle 1 completes; contagem=1; IDLE; no new cmd_enchimento.
- Timeout, TIMEOUT_CICLOS=20:
  - Stimulus: ench_concluida never rises.
  - Response: erro=1 exactly 20 cycles after ENCH entry; cmd_enchimento=0; erro stays high until reset.
- Timeout boundary:
  - Stimulus: ench_concluida rises on the cycle where timer=19.
  - Response: VEDA is entered and erro stays 0.
- Synchronous reset mid-LIBERA:
  - Stimulus: reset=1 for one cycle while garrafa_concluida=1.
  - Response: all outputs 0 and IDLE on that edge; contagem=0; reset asserted between edges has no effect until the next edge.
